spi_slave_interface: RTL and testbench

SPI responder for mode 3 (CPOL = 1, CPHA = 1), byte-oriented, the far-end counterpart of the team's SPI master. It samples the asynchronous SPI pins `scl`, `cs` and `mosi` into the system clock domain and shifts bytes in and out. It presents each received byte with a one-cycle strobe and requests the next transmit byte from local logic. It sits between an external SPI master pin group and a register file or FIFO in the `clk` domain.

---
 rtl/spi_slave_interface.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_interface.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_interface.sv
// rtl/spi_slave_interface.sv - SPI mode-3 byte responder with pin synchronizers
// Receives/transmits bytes over scl/cs/mosi/miso and hands them to clk-domain logic.
module spi_slave_interface #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic [7:0] byte_2_send,
  input  logic       msb_lsb,
  input  logic       ena_spi,
  output logic [7:0] byte_received,
  output logic       new_byte,
  output logic       tx_taken,
  output logic       end_trans,
  output logic       busy,
  input  logic       scl,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_t     state_q, state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] byte_received_q, byte_received_d;
  logic       new_byte_q, new_byte_d;
  logic       end_trans_q, end_trans_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;
  logic       tx_taken_d;

  logic       scl_s, cs_s, mosi_s;
  logic       scl_rise, scl_fall, cs_rise, cs_fall;
  logic [2:0] tx_idx, rx_idx;

  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    scl_prev_d  = scl_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign tx_idx = msb_lsb ? (3'd7 - tx_cnt_q[2:0]) : tx_cnt_q[2:0];
  assign rx_idx = msb_lsb ? (3'd7 - rx_cnt_q[2:0]) : rx_cnt_q[2:0];

  always_comb begin
    state_d         = state_q;
    rx_cnt_d        = rx_cnt_q;
    tx_cnt_d        = tx_cnt_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    byte_received_d = byte_received_q;
    new_byte_d      = 1'b0;
    end_trans_d     = 1'b0;
    miso_d          = miso_q;
    miso_oe_d       = miso_oe_q;
    tx_taken_d      = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        rx_cnt_d  = 4'd0;
        tx_cnt_d  = 4'd0;
        if (cs_fall && ena_spi) state_d = LOAD;
      end
      LOAD: begin
        if (!ena_spi) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (cs_rise) begin
          state_d     = IDLE;
          end_trans_d = 1'b1;
          miso_d      = 1'b0;
          miso_oe_d   = 1'b0;
        end else begin
          tx_shift_d = byte_2_send;
          tx_taken_d = 1'b1;
          miso_oe_d  = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (!ena_spi) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (cs_rise) begin
          state_d     = IDLE;
          end_trans_d = 1'b1;
          miso_d      = 1'b0;
          miso_oe_d   = 1'b0;
        end else if (rx_cnt_q == 4'd8) begin
          // Byte boundary: publish RX and fetch the next TX byte without leaving SHIFT
          byte_received_d = rx_shift_q;
          new_byte_d      = 1'b1;
          rx_cnt_d        = 4'd0;
          tx_cnt_d        = 4'd0;
          tx_shift_d      = byte_2_send;
          tx_taken_d      = 1'b1;
        end else begin
          if (scl_fall && (tx_cnt_q < 4'd8)) begin
            miso_d   = tx_shift_q[tx_idx];
            tx_cnt_d = tx_cnt_q + 4'd1;
          end
          if (scl_rise) begin
            rx_shift_d[rx_idx] = mosi_s;
            rx_cnt_d           = rx_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_sync_q      <= '1;
      cs_sync_q       <= '1;
      mosi_sync_q     <= '0;
      scl_prev_q      <= 1'b1;
      cs_prev_q       <= 1'b1;
      state_q         <= IDLE;
      rx_cnt_q        <= 4'd0;
      tx_cnt_q        <= 4'd0;
      rx_shift_q      <= 8'h00;
      tx_shift_q      <= 8'h00;
      byte_received_q <= 8'h00;
      new_byte_q      <= 1'b0;
      end_trans_q     <= 1'b0;
      miso_q          <= 1'b0;
      miso_oe_q       <= 1'b0;
    end else begin
      scl_sync_q      <= scl_sync_d;
      cs_sync_q       <= cs_sync_d;
      mosi_sync_q     <= mosi_sync_d;
      scl_prev_q      <= scl_prev_d;
      cs_prev_q       <= cs_prev_d;
      state_q         <= state_d;
      rx_cnt_q        <= rx_cnt_d;
      tx_cnt_q        <= tx_cnt_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      byte_received_q <= byte_received_d;
      new_byte_q      <= new_byte_d;
      end_trans_q     <= end_trans_d;
      miso_q          <= miso_d;
      miso_oe_q       <= miso_oe_d;
    end
  end

  assign byte_received = byte_received_q;
  assign new_byte      = new_byte_q;
  assign tx_taken      = tx_taken_d;
  assign end_trans     = end_trans_q;
  assign busy          = (state_q != IDLE);
  assign miso          = miso_q;
  assign miso_oe       = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_interface.sv
// tb/tb_spi_slave_interface.sv - directed bench for spi_slave_interface
// Acts as a mode-3 SPI master at 1 MHz against a 100 MHz system clock.
module tb_spi_slave_interface;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       arstn;
  logic [7:0] byte_2_send;
  logic       msb_lsb;
  logic       ena_spi;
  logic [7:0] byte_received;
  logic       new_byte;
  logic       tx_taken;
  logic       end_trans;
  logic       busy;
  logic       scl;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       miso_oe;

  int checks = 0;
  int errors = 0;

  int nb_cnt, tt_cnt, et_cnt, busy_cyc, oe_cyc;
  logic [7:0] nb_vals [$];

  spi_slave_interface #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .arstn(arstn), .byte_2_send(byte_2_send), .msb_lsb(msb_lsb),
    .ena_spi(ena_spi), .byte_received(byte_received), .new_byte(new_byte),
    .tx_taken(tx_taken), .end_trans(end_trans), .busy(busy), .scl(scl),
    .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arstn) begin
      if (new_byte) begin
        nb_cnt++;
        nb_vals.push_back(byte_received);
      end
      if (tx_taken) tt_cnt++;
      if (end_trans) et_cnt++;
      if (busy) busy_cyc++;
      if (miso_oe) oe_cyc++;
    end
  end

  task automatic clear_counts();
    nb_cnt = 0; tt_cnt = 0; et_cnt = 0; busy_cyc = 0; oe_cyc = 0;
    nb_vals.delete();
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic msb, output logic [7:0] rx);
    int idx;
    rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = msb ? 7 - i : i;
      scl = 1'b0;
      mosi = tx[idx];
      #500;
      scl = 1'b1;
      rx[idx] = miso;
      #500;
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      scl = 1'($urandom); cs = 1'($urandom); mosi = 1'($urandom);
      byte_2_send = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({byte_received, new_byte, tx_taken, end_trans, busy, miso, miso_oe} !== 14'h0) begin
        errors++;
        $display("FAIL reset_hold: outputs=%h required=0", {byte_received, new_byte, tx_taken, end_trans, busy, miso, miso_oe});
      end
    end
    scl = 1'b1; cs = 1'b1; mosi = 1'b0; byte_2_send = 8'h00;
    #100;
    arstn = 1'b1;
    #100;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required=0", busy);
    end
  endtask

  task automatic test_msb_single();
    logic [7:0] rx;
    clear_counts();
    msb_lsb = 1'b1; byte_2_send = 8'hA5;
    cs = 1'b0; #200;
    spi_byte(8'h3C, 1'b1, rx);
    #200; cs = 1'b1; #500;
    checks++;
    if (rx !== 8'hA5) begin errors++; $display("FAIL msb_master_rx: got=%h required=a5", rx); end
    checks++;
    if (byte_received !== 8'h3C) begin errors++; $display("FAIL msb_byte_received: got=%h required=3c", byte_received); end
    checks++;
    if (nb_cnt != 1) begin errors++; $display("FAIL msb_new_byte_count: got=%0d required=1", nb_cnt); end
    checks++;
    if (tt_cnt != 2) begin errors++; $display("FAIL msb_tx_taken_count: got=%0d required=2", tt_cnt); end
    checks++;
    if (et_cnt != 1) begin errors++; $display("FAIL msb_end_trans_count: got=%0d required=1", et_cnt); end
  endtask

  task automatic test_back_to_back_lsb();
    logic [7:0] rx0, rx1;
    clear_counts();
    msb_lsb = 1'b0; byte_2_send = 8'h55;
    cs = 1'b0; #100;
    byte_2_send = 8'hAA;
    #100;
    spi_byte(8'h01, 1'b0, rx0);
    spi_byte(8'h80, 1'b0, rx1);
    #200;
    checks++;
    if (et_cnt != 0) begin errors++; $display("FAIL b2b_end_trans_early: got=%0d required=0", et_cnt); end
    cs = 1'b1; #500;
    checks++;
    if (rx0 !== 8'h55) begin errors++; $display("FAIL b2b_master_rx0: got=%h required=55", rx0); end
    checks++;
    if (rx1 !== 8'hAA) begin errors++; $display("FAIL b2b_master_rx1: got=%h required=aa", rx1); end
    checks++;
    if (nb_cnt != 2) begin errors++; $display("FAIL b2b_new_byte_count: got=%0d required=2", nb_cnt); end
    if (nb_vals.size() == 2) begin
      checks++;
      if (nb_vals[0] !== 8'h01) begin errors++; $display("FAIL b2b_rx_byte0: got=%h required=01", nb_vals[0]); end
      checks++;
      if (nb_vals[1] !== 8'h80) begin errors++; $display("FAIL b2b_rx_byte1: got=%h required=80", nb_vals[1]); end
    end
    checks++;
    if (et_cnt != 1) begin errors++; $display("FAIL b2b_end_trans_count: got=%0d required=1", et_cnt); end
  endtask

  task automatic test_abort();
    clear_counts();
    msb_lsb = 1'b1; byte_2_send = 8'h11;
    cs = 1'b0; #200;
    for (int i = 0; i < 5; i++) begin
      scl = 1'b0; mosi = 1'b1; #500;
      scl = 1'b1; #500;
    end
    checks++;
    if (miso_oe !== 1'b1) begin errors++; $display("FAIL abort_oe_active: got=%b required=1", miso_oe); end
    cs = 1'b1;
    for (int i = 0; i < SYNC_STAGES + 2; i++) @(negedge clk);
    checks++;
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe_release: got=%b required=0", miso_oe); end
    #500;
    checks++;
    if (nb_cnt != 0) begin errors++; $display("FAIL abort_new_byte: got=%0d required=0", nb_cnt); end
    checks++;
    if (byte_received !== 8'h80) begin errors++; $display("FAIL abort_byte_received: got=%h required=80", byte_received); end
    checks++;
    if (et_cnt != 1) begin errors++; $display("FAIL abort_end_trans: got=%0d required=1", et_cnt); end
  endtask

  task automatic test_disabled();
    logic [7:0] rx;
    clear_counts();
    ena_spi = 1'b0; msb_lsb = 1'b1; byte_2_send = 8'hF0;
    cs = 1'b0; #200;
    spi_byte(8'h5A, 1'b1, rx);
    #200; cs = 1'b1; #500;
    checks++;
    if (busy_cyc != 0) begin errors++; $display("FAIL dis_busy: cycles=%0d required=0", busy_cyc); end
    checks++;
    if (oe_cyc != 0) begin errors++; $display("FAIL dis_miso_oe: cycles=%0d required=0", oe_cyc); end
    checks++;
    if (nb_cnt + tt_cnt + et_cnt != 0) begin
      errors++;
      $display("FAIL dis_strobes: new_byte=%0d tx_taken=%0d end_trans=%0d required=0", nb_cnt, tt_cnt, et_cnt);
    end
    checks++;
    if (byte_received !== 8'h80) begin errors++; $display("FAIL dis_byte_received: got=%h required=80", byte_received); end
    ena_spi = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] rx;
    clear_counts();
    msb_lsb = 1'b1; byte_2_send = 8'h96;
    cs = 1'b0; #200;
    for (int i = 0; i < 4; i++) begin
      scl = 1'b0; mosi = 1'b0; #500;
      scl = 1'b1; #500;
    end
    arstn = 1'b0;
    #3;
    checks++;
    if ({byte_received, busy, miso, miso_oe} !== 11'h0) begin
      errors++;
      $display("FAIL midrst_async: outputs=%h required=0", {byte_received, busy, miso, miso_oe});
    end
    #47;
    cs = 1'b1; scl = 1'b1;
    #100;
    arstn = 1'b1;
    #200;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy=%b required=0", busy); end
    cs = 1'b0; #200;
    spi_byte(8'hC3, 1'b1, rx);
    #200; cs = 1'b1; #500;
    checks++;
    if (byte_received !== 8'hC3) begin errors++; $display("FAIL midrst_byte_received: got=%h required=c3", byte_received); end
    checks++;
    if (rx !== 8'h96) begin errors++; $display("FAIL midrst_master_rx: got=%h required=96", rx); end
    checks++;
    if (nb_cnt != 1) begin errors++; $display("FAIL midrst_new_byte_count: got=%0d required=1", nb_cnt); end
  endtask

  initial begin
    arstn = 1'b0; scl = 1'b1; cs = 1'b1; mosi = 1'b0;
    byte_2_send = 8'h00; msb_lsb = 1'b1; ena_spi = 1'b1;
    clear_counts();
    test_reset();
    test_msb_single();
    test_back_to_back_lsb();
    test_abort();
    test_disabled();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
